// File: rtl/sr_latch_bank.sv
// WIDTH-bit state bank with run-time D / SR update modes, sticky change flags
// and an optional post-update hold window that drops requests while locked.
module sr_latch_bank #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned      HOLD_CYCLES = 0,
  parameter int unsigned      SR_PRIORITY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  input  logic             rw,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] reset,
  input  logic [WIDTH-1:0] clr_changed,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] changed,
  output logic             conflict,
  output logic             blocked,
  output logic             busy
);

  localparam int unsigned CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  localparam logic [0:0] ST_OPEN = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             conflict_q, conflict_d;
  logic             blocked_q, blocked_d;
  logic [WIDTH-1:0] sr_val;
  logic             req;
  logic             accept;

  assign req    = mode ? (|(set | reset)) : rw;
  assign accept = (state_q == ST_OPEN) && req;

  // Per-bit SR resolution; the both-high case follows SR_PRIORITY.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sr
    logic both_val;
    if (SR_PRIORITY == 1) begin : g_set_wins
      assign both_val = 1'b1;
    end else if (SR_PRIORITY == 2) begin : g_keep
      assign both_val = out_q[gi];
    end else begin : g_reset_wins
      assign both_val = 1'b0;
    end
    assign sr_val[gi] = (set[gi] && reset[gi]) ? both_val :
                        set[gi]                ? 1'b1     :
                        reset[gi]              ? 1'b0     : out_q[gi];
  end

  always_comb begin
    out_d      = out_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    conflict_d = 1'b0;
    blocked_d  = 1'b0;

    if (accept) begin
      out_d      = mode ? sr_val : data;
      conflict_d = mode && (|(set & reset));
    end

    if (state_q == ST_OPEN) begin
      // Even an equal-value write opens the hold window.
      if (accept && (HOLD_CYCLES != 0)) begin
        state_d = ST_HOLD;
        cnt_d   = HOLD_LOAD;
      end
    end else begin
      blocked_d = req;
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_OPEN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // A fresh toggle beats a simultaneous clear.
    changed_d = (changed_q & ~clr_changed) | (out_d ^ out_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= RESET_VAL;
      changed_q  <= '0;
      conflict_q <= 1'b0;
      blocked_q  <= 1'b0;
      state_q    <= ST_OPEN;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      changed_q  <= changed_d;
      conflict_q <= conflict_d;
      blocked_q  <= blocked_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out      = out_q;
  assign changed  = changed_q;
  assign conflict = conflict_q;
  assign blocked  = blocked_q;
  assign busy     = (state_q == ST_HOLD);

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench for sr_latch_bank: four instances (three SR policies with a
// 2-cycle hold, one without hold) share stimulus; expectations go through a queue.
module tb_sr_latch_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [3:0] data;
  logic       rw;
  logic [3:0] set;
  logic [3:0] reset;
  logic [3:0] clr_changed;

  logic [3:0] out_p0, changed_p0, out_p1, changed_p1, out_p2, changed_p2, out_h0, changed_h0;
  logic       conflict_p0, blocked_p0, busy_p0;
  logic       conflict_p1, blocked_p1, busy_p1;
  logic       conflict_p2, blocked_p2, busy_p2;
  logic       conflict_h0, blocked_h0, busy_h0;

  always #5 clk = ~clk;

  sr_latch_bank #(.WIDTH(4), .RESET_VAL(4'h0), .HOLD_CYCLES(2), .SR_PRIORITY(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .data(data), .rw(rw), .set(set), .reset(reset),
    .clr_changed(clr_changed), .out(out_p0), .changed(changed_p0), .conflict(conflict_p0),
    .blocked(blocked_p0), .busy(busy_p0));

  sr_latch_bank #(.WIDTH(4), .RESET_VAL(4'h0), .HOLD_CYCLES(2), .SR_PRIORITY(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .data(data), .rw(rw), .set(set), .reset(reset),
    .clr_changed(clr_changed), .out(out_p1), .changed(changed_p1), .conflict(conflict_p1),
    .blocked(blocked_p1), .busy(busy_p1));

  sr_latch_bank #(.WIDTH(4), .RESET_VAL(4'h0), .HOLD_CYCLES(2), .SR_PRIORITY(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .data(data), .rw(rw), .set(set), .reset(reset),
    .clr_changed(clr_changed), .out(out_p2), .changed(changed_p2), .conflict(conflict_p2),
    .blocked(blocked_p2), .busy(busy_p2));

  sr_latch_bank #(.WIDTH(4), .RESET_VAL(4'h0), .HOLD_CYCLES(0), .SR_PRIORITY(0)) u_h0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .data(data), .rw(rw), .set(set), .reset(reset),
    .clr_changed(clr_changed), .out(out_h0), .changed(changed_h0), .conflict(conflict_h0),
    .blocked(blocked_h0), .busy(busy_h0));

  localparam int P0_OUT = 0, P0_CHG = 1, P0_CONF = 2, P0_BLK = 3, P0_BUSY = 4;
  localparam int P1_OUT = 5, P1_CONF = 6, P2_OUT = 7, P2_CONF = 8;
  localparam int H0_OUT = 9, H0_BUSY = 10, H0_BLK = 11;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_n = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      P0_OUT:  return {28'd0, out_p0};
      P0_CHG:  return {28'd0, changed_p0};
      P0_CONF: return {31'd0, conflict_p0};
      P0_BLK:  return {31'd0, blocked_p0};
      P0_BUSY: return {31'd0, busy_p0};
      P1_OUT:  return {28'd0, out_p1};
      P1_CONF: return {31'd0, conflict_p1};
      P2_OUT:  return {28'd0, out_p2};
      P2_CONF: return {31'd0, conflict_p2};
      H0_OUT:  return {28'd0, out_h0};
      H0_BUSY: return {31'd0, busy_h0};
      H0_BLK:  return {31'd0, blocked_h0};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Advance one edge, then retire every expectation queued for that edge.
  task automatic tick();
    exp_t        e;
    logic [31:0] o;
    @(posedge clk);
    #1;
    step_n++;
    $display("step %0d: p0 out=%h chg=%h conf=%b blk=%b busy=%b | p1 out=%h p2 out=%h h0 out=%h",
             step_n, out_p0, changed_p0, conflict_p0, blocked_p0, busy_p0, out_p1, out_p2, out_h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; data = 4'h0; rw = 1'b0;
    set = 4'h0; reset = 4'h0; clr_changed = 4'h0;

    // Scenario 1: reset overrides a write request, then a D write opens the hold
    rw = 1'b1; data = 4'hA;
    expect_val(P0_OUT, 32'h0, "rst_out"); expect_val(P0_BUSY, 32'h0, "rst_busy");
    expect_val(P0_CHG, 32'h0, "rst_changed"); expect_val(P0_CONF, 32'h0, "rst_conflict");
    expect_val(P0_BLK, 32'h0, "rst_blocked"); expect_val(H0_OUT, 32'h0, "rst_h0_out");
    tick();
    rst_n = 1'b1;
    expect_val(P0_OUT, 32'hA, "d_write_out"); expect_val(P0_CHG, 32'hA, "d_write_changed");
    expect_val(P0_BUSY, 32'h1, "hold_busy_c1"); expect_val(P0_CONF, 32'h0, "d_no_conflict");
    tick();
    rw = 1'b0;
    expect_val(P0_BUSY, 32'h1, "hold_busy_c2"); expect_val(P0_OUT, 32'hA, "hold_out_c2");
    expect_val(P0_BLK, 32'h0, "hold_no_req_blk");
    tick();
    expect_val(P0_BUSY, 32'h0, "hold_busy_end");
    tick();

    // Scenario 2: set/reset conflict under each priority policy
    rst_n = 1'b0;
    expect_val(P0_OUT, 32'h0, "rst2_out");
    tick();
    rst_n = 1'b1; mode = 1'b1; set = 4'b0011; reset = 4'b0110;
    expect_val(P0_OUT, 32'b0001, "sr_p0_out"); expect_val(P0_CONF, 32'h1, "sr_p0_conflict");
    expect_val(P0_CHG, 32'b0001, "sr_p0_changed");
    expect_val(P1_OUT, 32'b0011, "sr_p1_out"); expect_val(P1_CONF, 32'h1, "sr_p1_conflict");
    expect_val(P2_OUT, 32'b0001, "sr_p2_out"); expect_val(P2_CONF, 32'h1, "sr_p2_conflict");
    tick();
    set = 4'h0; reset = 4'h0;
    expect_val(P0_CONF, 32'h0, "conflict_one_cycle"); expect_val(P2_CONF, 32'h0, "p2_conflict_one_cycle");
    expect_val(P0_BLK, 32'h0, "sr_idle_blk");
    tick();
    tick();

    // Scenario 3: requests during hold are dropped and flagged
    mode = 1'b0; rw = 1'b1; data = 4'h5;
    expect_val(P0_OUT, 32'h5, "h3_write5"); expect_val(P0_CHG, 32'h5, "h3_changed");
    tick();
    data = 4'hF;
    expect_val(P0_OUT, 32'h5, "h3_blocked1_out"); expect_val(P0_BLK, 32'h1, "h3_blocked1");
    expect_val(P0_BUSY, 32'h1, "h3_busy1");
    tick();
    expect_val(P0_OUT, 32'h5, "h3_blocked2_out"); expect_val(P0_BLK, 32'h1, "h3_blocked2");
    expect_val(P0_BUSY, 32'h0, "h3_busy_end");
    tick();
    expect_val(P0_OUT, 32'hF, "h3_accept_out"); expect_val(P0_BLK, 32'h0, "h3_accept_noblk");
    expect_val(P0_CHG, 32'hF, "h3_changed_F"); expect_val(P0_BUSY, 32'h1, "h3_rehold");
    tick();
    rw = 1'b0;
    tick();
    tick();

    // Scenario 4: sticky changed flags and clear-vs-toggle
    clr_changed = 4'hF;
    expect_val(P0_CHG, 32'h0, "clr_all"); expect_val(P0_OUT, 32'hF, "clr_out_hold");
    tick();
    clr_changed = 4'h0; rw = 1'b1; data = 4'hB;
    expect_val(P0_OUT, 32'hB, "toggle_b2_out"); expect_val(P0_CHG, 32'b0100, "toggle_b2_chg");
    tick();
    rw = 1'b0;
    expect_val(P0_CHG, 32'b0100, "sticky_hold");
    tick();
    clr_changed = 4'b0100;
    expect_val(P0_CHG, 32'h0, "clr_b2"); expect_val(P0_BUSY, 32'h0, "s4_open");
    tick();
    rw = 1'b1; data = 4'hF;
    expect_val(P0_OUT, 32'hF, "toggle_clr_out"); expect_val(P0_CHG, 32'b0100, "toggle_beats_clr");
    tick();
    rw = 1'b0; clr_changed = 4'h0;
    tick();
    tick();

    // Scenario 5: reset in the middle of a hold window
    rw = 1'b1; data = 4'h3;
    expect_val(P0_OUT, 32'h3, "s5_write"); expect_val(P0_CHG, 32'b1100, "s5_changed");
    expect_val(P0_BUSY, 32'h1, "s5_busy");
    tick();
    rst_n = 1'b0; data = 4'h7;
    expect_val(P0_OUT, 32'h0, "s5_rst_out"); expect_val(P0_BUSY, 32'h0, "s5_rst_busy");
    expect_val(P0_CHG, 32'h0, "s5_rst_chg"); expect_val(P0_BLK, 32'h0, "s5_rst_blk");
    tick();
    rst_n = 1'b1; data = 4'h6;
    expect_val(P0_OUT, 32'h6, "s5_post_rst_write"); expect_val(P0_BLK, 32'h0, "s5_post_noblk");
    tick();
    rw = 1'b0;
    tick();
    tick();

    // Scenario 6: no hold window, back-to-back writes
    rst_n = 1'b0;
    expect_val(H0_OUT, 32'h0, "h0_rst");
    tick();
    rst_n = 1'b1; rw = 1'b1; data = 4'h1;
    expect_val(H0_OUT, 32'h1, "h0_w1"); expect_val(H0_BUSY, 32'h0, "h0_busy1");
    tick();
    data = 4'h2;
    expect_val(H0_OUT, 32'h2, "h0_w2"); expect_val(H0_BLK, 32'h0, "h0_blk2");
    expect_val(P0_OUT, 32'h1, "p0_w2_dropped"); expect_val(P0_BLK, 32'h1, "p0_w2_blk");
    tick();
    data = 4'h3;
    expect_val(H0_OUT, 32'h3, "h0_w3"); expect_val(H0_BUSY, 32'h0, "h0_busy3");
    expect_val(H0_BLK, 32'h0, "h0_blk3");
    tick();
    rw = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
